// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of branch_predictor: prediction lookup plus
// update handshake. master = core side, slave = predictor.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic            upd_ready;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_instruction;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic [31:0]     mispredict_count;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_instruction, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, upd_ready, mispredict_count
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_instruction, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, upd_ready, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter branch predictor with post-reset table clear walk.
// Optional gshare counter indexing enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [1:0] T_BR   = 2'd0;
    localparam logic [1:0] T_JAL  = 2'd1;
    localparam logic [1:0] T_JALR = 2'd2;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q;
    logic [IDX-1:0]   init_idx_q;
    logic             ready_q;
    logic [31:0]      mis_cnt_q;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       type_q   [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [6:0]       opcode;
    logic             is_br, is_jal, is_jalr, is_ctl, accept, mispred;
    logic [IDX-1:0]   u_idx, u_cidx, f_idx, f_cidx;
    logic [TAG_W-1:0] u_tag, f_tag;

    assign opcode  = bp.upd_instruction[6:0];
    assign is_br   = (opcode == 7'b1100011);
    assign is_jal  = (opcode == 7'b1101111);
    assign is_jalr = (opcode == 7'b1100111);
    assign is_ctl  = is_br | is_jal | is_jalr;
    assign accept  = bp.upd_valid & ready_q;
    assign mispred = (bp.upd_taken != bp.upd_pred_taken) ||
                     (bp.upd_taken && (bp.upd_target != bp.upd_pred_target));

    assign u_idx = bp.upd_pc[IDX+1:2];
    assign u_tag = bp.upd_pc[XLEN-1:IDX+2];
    assign f_idx = bp.fetch_pc[IDX+1:2];
    assign f_tag = bp.fetch_pc[XLEN-1:IDX+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    // Only the counter table is hashed with history; the BTB stays PC-indexed.
    assign u_cidx = u_idx ^ IDX'(ghr_q);
    assign f_cidx = f_idx ^ IDX'(ghr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ghr_q <= '0;
        else if (state_q == S_RUN && accept && is_br)
            ghr_q <= {ghr_q[GHR_BITS-2:0], bp.upd_taken};
    end
`else
    localparam int unused_ghr_bits = GHR_BITS;
    assign u_cidx = u_idx;
    assign f_cidx = f_idx;
`endif

    logic unused_bits;
    assign unused_bits = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0], bp.upd_instruction[XLEN-1:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            mis_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == IDX'(ENTRIES - 1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept && is_ctl && mispred)
                        mis_cnt_q <= mis_cnt_q + 32'd1;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    // Table storage: cleared by the init walk, never by reset itself.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            valid_q[init_idx_q] <= 1'b0;
            cnt_q[init_idx_q]   <= 2'b01;
        end else if (accept) begin
            if (is_br) begin
                cnt_q[u_cidx] <= ctr_next(cnt_q[u_cidx], bp.upd_taken);
                if (bp.upd_taken) begin
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= bp.upd_target;
                    type_q[u_idx]   <= T_BR;
                end
            end else if (is_jal || is_jalr) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= bp.upd_target;
                type_q[u_idx]   <= is_jal ? T_JAL : T_JALR;
            end
        end
    end

    logic hit, taken_c;

    always_comb begin
        hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        taken_c = 1'b0;
        if (state_q == S_RUN && hit)
            taken_c = (type_q[f_idx] == T_BR) ? cnt_q[f_cidx][1] : 1'b1;
    end

    assign bp.pred_taken       = taken_c;
    assign bp.pred_target      = taken_c ? target_q[f_idx] : '0;
    assign bp.upd_ready        = ready_q;
    assign bp.mispredict_count = mis_cnt_q;
endmodule
